classificador_botao: RTL and testbench

- Upstream stage of the automatic-lighting lamp FSM. Conditions the raw push-button and measures how long it is held (Tp).
- Emits one-cycle condition pulses: `a_longo` when Tp >= 5 s, `b_curto` when 300 ms < Tp < 5 s. These drive the lamp FSM's a/b inputs.
- Also exports the debounced button level, for status.

---
 rtl/iluminacao_pkg.sv | 16 +
 rtl/debounce_botao.sv | 45 ++++
 rtl/classificador_botao.sv | 86 ++++++++
 tb/tb_classificador_botao.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/iluminacao_pkg.sv
// Shared types and default timing constants for the automatic-lighting blocks.
// Defaults assume a 50 MHz clock.
package iluminacao_pkg;

  typedef enum logic [1:0] {
    OCIOSO        = 2'd0,
    PRESSIONADO   = 2'd1,
    ESPERA_SOLTAR = 2'd2
  } estado_botao_t;

  localparam int DEB_CYC_DEF   = 50_000;       // 1 ms
  localparam int SHORT_CYC_DEF = 15_000_000;   // 300 ms
  localparam int LONG_CYC_DEF  = 250_000_000;  // 5 s
  localparam int CNT_W_DEF     = 28;

endpackage

// File: rtl/debounce_botao.sv
// Two-flop synchronizer followed by a stability counter; a level change is
// accepted only after DEB_CYC consecutive cycles of disagreement.
module debounce_botao
  import iluminacao_pkg::*;
#(
  parameter int DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the 2-FF chain work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= in;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYC - 1)) begin
        r_db  <= r_sync2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign out = r_db;

endmodule

// File: rtl/classificador_botao.sv
// Classifies debounced button presses by hold time into long (a_longo) and
// short (b_curto) one-cycle pulses for the lamp FSM.
module classificador_botao
  import iluminacao_pkg::*;
#(
  parameter int DEB_CYC   = DEB_CYC_DEF,
  parameter int SHORT_CYC = SHORT_CYC_DEF,
  parameter int LONG_CYC  = LONG_CYC_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  output logic pressionado,
  output logic a_longo,
  output logic b_curto
);

  logic             w_btn_db;
  estado_botao_t    r_estado;
  logic [CNT_W-1:0] r_cnt;
  logic             r_a_longo;
  logic             r_b_curto;

  debounce_botao #(
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk (clk),
    .rst (rst),
    .in  (push),
    .out (w_btn_db)
  );

  // r_cnt equals the number of cycles btn_db has been high, so on the release
  // cycle it is exactly the hold time Tp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado  <= OCIOSO;
      r_cnt     <= '0;
      r_a_longo <= 1'b0;
      r_b_curto <= 1'b0;
    end else begin
      r_a_longo <= 1'b0;
      r_b_curto <= 1'b0;
      case (r_estado)
        OCIOSO: begin
          if (w_btn_db) begin
            r_estado <= PRESSIONADO;
            r_cnt    <= CNT_W'(1);
          end else begin
            r_cnt <= '0;
          end
        end
        PRESSIONADO: begin
          if (w_btn_db) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(LONG_CYC - 1)) begin
              r_a_longo <= 1'b1;
              r_estado  <= ESPERA_SOLTAR;
            end
          end else begin
            r_b_curto <= (r_cnt > CNT_W'(SHORT_CYC));
            r_estado  <= OCIOSO;
            r_cnt     <= '0;
          end
        end
        ESPERA_SOLTAR: begin
          // Counter frozen while waiting for release so it can never wrap.
          if (!w_btn_db) begin
            r_estado <= OCIOSO;
            r_cnt    <= '0;
          end
        end
        default: begin
          r_estado <= OCIOSO;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign pressionado = w_btn_db;
  assign a_longo     = r_a_longo;
  assign b_curto     = r_b_curto;

endmodule

// File: tb/tb_classificador_botao.sv
// Directed bench for classificador_botao with small timing parameters
// (DEB=4, SHORT=10, LONG=40).
module tb_classificador_botao;

  localparam int DEB   = 4;
  localparam int SHORT = 10;
  localparam int LONG  = 40;
  localparam int LAT   = 2 + DEB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic push = 1'b0;
  logic pressionado, a_longo, b_curto;

  int checks = 0;
  int errors = 0;

  // Results of the last observe() window, indexed by cycles since stimulus start.
  int rise_cyc, fall_cyc, high_cnt;
  int n_a, a_cyc, n_b, b_cyc, viol;

  classificador_botao #(
    .DEB_CYC   (DEB),
    .SHORT_CYC (SHORT),
    .LONG_CYC  (LONG),
    .CNT_W     (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .pressionado (pressionado),
    .a_longo     (a_longo),
    .b_curto     (b_curto)
  );

  always #5 clk = ~clk;

  // Samples outputs on negedges for 'cycles' cycles; drops push after cycle
  // 'release_at' (negative = keep push as is).
  task automatic observe(input int cycles, input int release_at);
    logic prev_p, prev_pulse;
    rise_cyc = -1; fall_cyc = -1; high_cnt = 0;
    n_a = 0; a_cyc = -1; n_b = 0; b_cyc = -1; viol = 0;
    prev_p = pressionado;
    prev_pulse = 1'b0;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pressionado && !prev_p && rise_cyc < 0) rise_cyc = i;
      if (!pressionado && prev_p && fall_cyc < 0) fall_cyc = i;
      if (pressionado) high_cnt++;
      if (a_longo) begin n_a++; if (a_cyc < 0) a_cyc = i; end
      if (b_curto) begin n_b++; if (b_cyc < 0) b_cyc = i; end
      if ((a_longo && b_curto) || ((a_longo || b_curto) && prev_pulse)) viol++;
      prev_pulse = a_longo | b_curto;
      prev_p = pressionado;
      if (i == release_at) push = 1'b0;
    end
  endtask

  task automatic press(input int hold);
    push = 1'b1;
    observe(hold + 15, hold);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({pressionado, a_longo, b_curto} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000", {pressionado, a_longo, b_curto});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({pressionado, a_longo, b_curto} !== 3'b000) begin
      errors++;
      $display("FAIL post_reset_idle: got %b expected 000", {pressionado, a_longo, b_curto});
    end
  endtask

  task automatic test_glitch;
    press(3);
    checks++;
    if (rise_cyc !== -1 || high_cnt !== 0) begin
      errors++;
      $display("FAIL glitch_level: rise %0d high %0d expected no rise", rise_cyc, high_cnt);
    end
    checks++;
    if (n_a !== 0 || n_b !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: a %0d b %0d expected 0 0", n_a, n_b);
    end
  endtask

  task automatic test_short_press;
    press(20);
    checks++;
    if (rise_cyc !== LAT || fall_cyc !== 20 + LAT || high_cnt !== 20) begin
      errors++;
      $display("FAIL short20_level: rise %0d fall %0d high %0d expected %0d %0d 20",
               rise_cyc, fall_cyc, high_cnt, LAT, 20 + LAT);
    end
    checks++;
    if (n_b !== 1 || b_cyc !== 20 + LAT + 1) begin
      errors++;
      $display("FAIL short20_b: count %0d cycle %0d expected 1 at %0d", n_b, b_cyc, 20 + LAT + 1);
    end
    checks++;
    if (n_a !== 0 || viol !== 0) begin
      errors++;
      $display("FAIL short20_a: a %0d viol %0d expected 0 0", n_a, viol);
    end
  endtask

  task automatic test_short_bound;
    press(SHORT);
    checks++;
    if (n_a !== 0 || n_b !== 0) begin
      errors++;
      $display("FAIL short_eq_bound: a %0d b %0d expected 0 0", n_a, n_b);
    end
    press(SHORT + 1);
    checks++;
    if (n_a !== 0 || n_b !== 1 || b_cyc !== SHORT + 1 + LAT + 1) begin
      errors++;
      $display("FAIL short_above_bound: a %0d b %0d at %0d expected 0 1 at %0d",
               n_a, n_b, b_cyc, SHORT + 1 + LAT + 1);
    end
  endtask

  task automatic test_long_bound;
    press(LONG - 1);
    checks++;
    if (n_a !== 0 || n_b !== 1 || b_cyc !== LONG + LAT) begin
      errors++;
      $display("FAIL long_minus1: a %0d b %0d at %0d expected 0 1 at %0d",
               n_a, n_b, b_cyc, LONG + LAT);
    end
    press(LONG);
    checks++;
    if (n_a !== 1 || a_cyc !== LAT + LONG || n_b !== 0) begin
      errors++;
      $display("FAIL long_eq: a %0d at %0d b %0d expected 1 at %0d 0",
               n_a, a_cyc, n_b, LAT + LONG);
    end
  endtask

  task automatic test_long_hold;
    press(100);
    checks++;
    if (n_a !== 1 || a_cyc !== rise_cyc + LONG || rise_cyc !== LAT) begin
      errors++;
      $display("FAIL hold100_a: a %0d at %0d rise %0d expected 1 at %0d rise %0d",
               n_a, a_cyc, rise_cyc, LAT + LONG, LAT);
    end
    checks++;
    if (n_b !== 0 || viol !== 0) begin
      errors++;
      $display("FAIL hold100_extra: b %0d viol %0d expected 0 0", n_b, viol);
    end
  endtask

  task automatic test_reset_mid;
    push = 1'b1;
    // btn_db rises at cycle LAT; the press count reaches 30 at cycle LAT+30.
    observe(LAT + 30, -1);
    checks++;
    if (n_a !== 0 || n_b !== 0 || pressionado !== 1'b1) begin
      errors++;
      $display("FAIL mid_before_rst: a %0d b %0d p %b expected 0 0 1", n_a, n_b, pressionado);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({pressionado, a_longo, b_curto} !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst_async: got %b expected 000", {pressionado, a_longo, b_curto});
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    observe(LAT + LONG + 10, -1);
    checks++;
    if (rise_cyc !== LAT || n_a !== 1 || a_cyc !== LAT + LONG || n_b !== 0) begin
      errors++;
      $display("FAIL mid_new_press: rise %0d a %0d at %0d b %0d expected %0d 1 at %0d 0",
               rise_cyc, n_a, a_cyc, n_b, LAT, LAT + LONG);
    end
    push = 1'b0;
    observe(15, -1);
    checks++;
    if (n_a !== 0 || n_b !== 0 || pressionado !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: a %0d b %0d p %b expected 0 0 0", n_a, n_b, pressionado);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_short_press();
    test_short_bound();
    test_long_bound();
    test_long_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
